// File: rtl/input_conditioner.sv
// input_conditioner
//   Conditions board pushbuttons / slide switches into clean single-clock events.
//   Each channel has its own synchroniser, debounce filter, press/release pulse
//   generator, hold counter and optional auto-repeat strobe. No state is shared
//   between channels.
//
// Ports
//   clock      in   1       system clock
//   reset_n    in   1       asynchronous reset, active-low
//   raw_in     in   NUM_CH  asynchronous pin levels
//   level      out  NUM_CH  debounced state, 1 = asserted (polarity applied)
//   press      out  NUM_CH  one-cycle pulse on level 0->1
//   release_p  out  NUM_CH  one-cycle pulse on level 1->0 ("release" is a
//                           reserved word, hence the suffix)
//   strobe     out  NUM_CH  press pulse plus auto-repeat pulses
//   held_long  out  NUM_CH  1 while level=1 and hold time >= REPEAT_DELAY
module input_conditioner #(
   parameter int unsigned NUM_CH          = 4,
   parameter int unsigned ACTIVE_LOW      = 1,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_EN       = 0,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_PERIOD   = 5000000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] raw_in,
   output logic [NUM_CH-1:0] level,
   output logic [NUM_CH-1:0] press,
   output logic [NUM_CH-1:0] release_p,
   output logic [NUM_CH-1:0] strobe,
   output logic [NUM_CH-1:0] held_long
);

   localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned HOLD_MAX = REPEAT_DELAY + REPEAT_PERIOD - 1;
   localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic              IDLE_PIN   = (ACTIVE_LOW != 0);
   localparam logic              REP_ON     = (REPEAT_EN != 0);
   localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_DELAY = HOLD_W'(REPEAT_DELAY);
   localparam logic [HOLD_W-1:0] HOLD_SAT   = HOLD_W'(HOLD_MAX);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [DB_W-1:0]        db_q, db_d;
      logic [HOLD_W-1:0]      hold_q, hold_d;
      logic level_q, level_d;
      logic press_q, press_d;
      logic rel_q, rel_d;
      logic strobe_q, strobe_d;
      logic held_q, held_d;
      logic s, flip;

      always_comb begin
         sync_d = {sync_q[SYNC_STAGES-2:0], raw_in[i]};
         // polarity-corrected synchronised input: 1 = asserted
         s      = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

         db_d = '0;
         flip = 1'b0;
         if (s != level_q) begin
            if (db_q == DB_LAST) begin
               flip = 1'b1;
            end else begin
               db_d = db_q + 1'b1;
            end
         end

         level_d = level_q ^ flip;
         press_d = flip & ~level_q;
         rel_d   = flip & level_q;

         // Hold counter runs only while level stays 1; after reaching the last
         // count of a repeat period it jumps back to REPEAT_DELAY so every
         // later period re-hits the same strobe count.
         hold_d = '0;
         if (level_q && !rel_d) begin
            if (hold_q == HOLD_SAT) begin
               hold_d = HOLD_DELAY;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end

         strobe_d = press_d | (REP_ON & level_q & ~rel_d & (hold_d == HOLD_DELAY));
         held_d   = level_d & (hold_d >= HOLD_DELAY);
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{IDLE_PIN}};
            db_q     <= '0;
            hold_q   <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            strobe_q <= 1'b0;
            held_q   <= 1'b0;
         end else begin
            sync_q   <= sync_d;
            db_q     <= db_d;
            hold_q   <= hold_d;
            level_q  <= level_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            strobe_q <= strobe_d;
            held_q   <= held_d;
         end
      end

      assign level[i]     = level_q;
      assign press[i]     = press_q;
      assign release_p[i] = rel_q;
      assign strobe[i]    = strobe_q;
      assign held_long[i] = held_q;
   end

endmodule
